// File: rtl/mem_responder.sv
// mem_responder -- single-port word memory behind a valid/ready request and
// response handshake, with a fixed number of wait states per access.
//
// Parameters
//   DEPTH_WORDS  number of 32-bit storage words (default 1024)
//   WAIT_CYCLES  wait states between request acceptance and response, 0..15
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   req_valid  initiator presents a request
//   req_ready  responder can accept a request this cycle (IDLE only)
//   req_we     1 = write, 0 = read
//   req_be     byte-lane write enables, bit i covers bits 8i+7:8i
//   req_adr    byte address; word index is req_adr[31:2]
//   req_wdata  write data
//   rsp_valid  response available, held until rsp_ready
//   rsp_ready  initiator accepts the response
//   rsp_rdata  read data; 0 for writes and errored requests
//   rsp_err    request addressed outside storage (or misaligned, see below)
//
// Build option
//   MEM_MISALIGN_CHECK_EN  when defined, any request with req_adr[1:0] != 0
//                          is answered with rsp_err=1 and has no effect.
//                          When undefined, req_adr[1:0] is ignored.
//
// Timing: a request accepted at edge N raises rsp_valid after edge
// N+1+WAIT_CYCLES. A write commits and a read samples storage on the edge
// that enters RESP.

module mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [3:0]  req_be,
  input  logic [31:0] req_adr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      state;
  state_t      state_n;
  logic [3:0]  wait_cnt;

  // Request captured at acceptance; inputs are ignored afterwards.
  logic        lat_we;
  logic [3:0]  lat_be;
  logic [31:0] lat_adr;
  logic [31:0] lat_wdata;

  logic [31:0] mem [DEPTH_WORDS];

  logic [IDX_W-1:0] mem_idx;
  logic             in_range;
  logic             misaligned;
  logic             access_ok;
  logic             enter_resp;

  assign mem_idx  = lat_adr[IDX_W+1:2];
  assign in_range = {2'b00, lat_adr[31:2]} < 32'(DEPTH_WORDS);

`ifdef MEM_MISALIGN_CHECK_EN
  assign misaligned = lat_adr[1:0] != 2'b00;
`else
  // Low address bits are don't-care in this build.
  logic unused_adr_lsb;
  assign unused_adr_lsb = ^lat_adr[1:0];
  assign misaligned     = 1'b0;
`endif

  assign access_ok  = in_range && !misaligned;
  assign enter_resp = (state == S_WAIT) && (wait_cnt == 4'd0);

  assign req_ready = (state == S_IDLE);
  assign rsp_valid = (state == S_RESP);

  // ---------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  // ---------------------------------------------------------------------
  // FSM next-state logic
  // ---------------------------------------------------------------------
  // NOTE: state_n gets a default before the case so no path leaves it
  // unassigned -- that is what keeps this block from inferring a latch.
  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE: if (req_valid)          state_n = S_WAIT;
      S_WAIT: if (wait_cnt == 4'd0)   state_n = S_RESP;
      S_RESP: if (rsp_ready)          state_n = S_IDLE;
      default:                        state_n = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Wait counter and response registers
  // ---------------------------------------------------------------------
  // The WAIT state always lasts WAIT_CYCLES+1 cycles: one decode cycle
  // after acceptance plus the configured wait states. With WAIT_CYCLES=0
  // this still gives the one-cycle minimum latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt  <= 4'd0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (req_valid) wait_cnt <= 4'(WAIT_CYCLES);
        end
        S_WAIT: begin
          if (wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
          end else begin
            rsp_err   <= !access_ok;
            rsp_rdata <= (!lat_we && access_ok) ? mem[mem_idx] : 32'd0;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Request latch: no reset needed, contents only matter after acceptance.
  always_ff @(posedge clk) begin
    if (!reset && req_ready && req_valid) begin
      lat_we    <= req_we;
      lat_be    <= req_be;
      lat_adr   <= req_adr;
      lat_wdata <= req_wdata;
    end
  end

  // ---------------------------------------------------------------------
  // Storage write port
  // ---------------------------------------------------------------------
  // NOTE: the storage array has no reset branch; contents survive reset and
  // the array maps onto plain RAM. Reset only gates the write enable, so a
  // request abandoned by reset never commits.
  always_ff @(posedge clk) begin
    if (!reset && enter_resp && lat_we && access_ok) begin
      for (int i = 0; i < 4; i++) begin
        if (lat_be[i]) mem[mem_idx][8*i +: 8] <= lat_wdata[8*i +: 8];
      end
    end
  end

endmodule
